// File: rtl/mmu_page_pool_pkg.sv
// rtl/mmu_page_pool_pkg.sv - shared types and constants for the page pool
package mmu_page_pool_pkg;

    localparam int REASON_W = 3;

    localparam logic [REASON_W-1:0] REASON_NONE          = 3'd0;
    localparam logic [REASON_W-1:0] REASON_INVALID_SIZE  = 3'd1;
    localparam logic [REASON_W-1:0] REASON_OUT_OF_MEMORY = 3'd2;
    localparam logic [REASON_W-1:0] REASON_MISALIGNED    = 3'd3;
    localparam logic [REASON_W-1:0] REASON_OUT_OF_RANGE  = 3'd4;
    localparam logic [REASON_W-1:0] REASON_DOUBLE_FREE   = 3'd5;

    // Largest legal size type: 512B << 3 = 4K.
    localparam int MAX_ALLOC_SIZE = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ALLOC = 2'd2,
        ST_FREE  = 2'd3
    } pool_state_t;

endpackage

// File: rtl/mmu_page_pool_sync_fifo.sv
// rtl/mmu_page_pool_sync_fifo.sv - synchronous FIFO used as the page free list
module mmu_page_pool_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write and registered read: popped data is valid the cycle after pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
        if (do_pop)  pop_data    <= mem[rd_ptr];
    end

endmodule

// File: rtl/mmu_page_pool.sv
// rtl/mmu_page_pool.sv - 4K page allocator with free list and ownership bitmap
module mmu_page_pool
    import mmu_page_pool_pkg::*;
#(
    parameter int PAGE_COUNT = 4096,
    parameter int PAGE_W     = 12,
    parameter int SUB_W      = 3,
    parameter int IDX_W      = 15,
    parameter int ID_W       = 8,
    parameter int SIZE_W     = 3,
    parameter int REASON_W   = mmu_page_pool_pkg::REASON_W
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                alloc_req_pop,
    input  logic [ID_W-1:0]     alloc_req_id,
    input  logic [SIZE_W-1:0]   alloc_req_size,
    input  logic                alloc_fifo_empty,
    output logic                free_req_pop,
    input  logic [ID_W-1:0]     free_req_id,
    input  logic [IDX_W-1:0]    free_req_page_idx,
    input  logic                free_fifo_empty,
    output logic                alloc_rsp_write_en,
    output logic [ID_W-1:0]     alloc_rsp_id,
    output logic [IDX_W-1:0]    alloc_rsp_page_idx,
    output logic                alloc_rsp_fail,
    output logic [REASON_W-1:0] alloc_rsp_fail_reason,
    output logic                free_rsp_write_en,
    output logic [ID_W-1:0]     free_rsp_id,
    output logic                free_rsp_fail,
    output logic [REASON_W-1:0] free_rsp_fail_reason,
    output logic                pool_ready,
    output logic [PAGE_W:0]     free_page_count
);

    pool_state_t           state, state_nxt;
    logic [PAGE_W-1:0]     init_cnt;
    logic [PAGE_COUNT-1:0] bitmap;
    logic                  last_served_alloc;

    logic [ID_W-1:0]       alloc_id_q;
    logic [SIZE_W-1:0]     alloc_size_q;
    logic                  alloc_fl_avail_q;
    logic [ID_W-1:0]       free_id_q;
    logic [IDX_W-1:0]      free_idx_q;

    logic                  fl_push, fl_pop, fl_empty, fl_full;
    logic [PAGE_W-1:0]     fl_push_data, fl_pop_data;

    logic                  init_last, serve_alloc, size_ok_now;
    logic                  alloc_size_bad, alloc_ok;
    logic                  free_misaligned, free_out_of_range, free_owned, free_ok;
    logic [PAGE_W-1:0]     free_page;

    assign init_last   = (init_cnt == PAGE_W'(PAGE_COUNT - 1));
    assign serve_alloc = !alloc_fifo_empty && (free_fifo_empty || !last_served_alloc);
    assign size_ok_now = (alloc_req_size <= SIZE_W'(MAX_ALLOC_SIZE));

    assign alloc_size_bad = (alloc_size_q > SIZE_W'(MAX_ALLOC_SIZE));
    assign alloc_ok       = (state == ST_ALLOC) && !alloc_size_bad && alloc_fl_avail_q;

    assign free_page         = free_idx_q[SUB_W +: PAGE_W];
    assign free_misaligned   = |free_idx_q[SUB_W-1:0];
    assign free_out_of_range = (({1'b0, free_idx_q} >> SUB_W) >= (IDX_W+1)'(PAGE_COUNT));
    assign free_owned        = bitmap[free_page];
    assign free_ok           = (state == ST_FREE) && !free_misaligned && !free_out_of_range && free_owned;

    mmu_page_pool_sync_fifo #(
        .DEPTH (PAGE_COUNT),
        .WIDTH (PAGE_W)
    ) u_free_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fl_push),
        .push_data (fl_push_data),
        .pop       (fl_pop),
        .pop_data  (fl_pop_data),
        .empty     (fl_empty),
        .full      (fl_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    // Next state, request pops and free-list push/pop control.
    always_comb begin
        state_nxt     = state;
        alloc_req_pop = 1'b0;
        free_req_pop  = 1'b0;
        fl_pop        = 1'b0;
        fl_push       = 1'b0;
        fl_push_data  = init_cnt;
        case (state)
            ST_INIT: begin
                fl_push = 1'b1;
                if (init_last) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (serve_alloc) begin
                    alloc_req_pop = 1'b1;
                    fl_pop        = !fl_empty && size_ok_now;
                    state_nxt     = ST_ALLOC;
                end else if (!free_fifo_empty) begin
                    free_req_pop = 1'b1;
                    state_nxt    = ST_FREE;
                end
            end
            ST_ALLOC: state_nxt = ST_IDLE;
            ST_FREE: begin
                state_nxt = ST_IDLE;
                if (free_ok) begin
                    fl_push      = 1'b1;
                    fl_push_data = free_page;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Initialisation sweep, arbitration history and request capture at the pop cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt          <= '0;
            pool_ready        <= 1'b0;
            last_served_alloc <= 1'b0;
            alloc_id_q        <= '0;
            alloc_size_q      <= '0;
            alloc_fl_avail_q  <= 1'b0;
            free_id_q         <= '0;
            free_idx_q        <= '0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + PAGE_W'(1);
                if (init_last) pool_ready <= 1'b1;
            end
            if (alloc_req_pop) begin
                last_served_alloc <= 1'b1;
                alloc_id_q        <= alloc_req_id;
                alloc_size_q      <= alloc_req_size;
                alloc_fl_avail_q  <= !fl_empty;
            end
            if (free_req_pop) begin
                last_served_alloc <= 1'b0;
                free_id_q         <= free_req_id;
                free_idx_q        <= free_req_page_idx;
            end
        end
    end

    // Ownership bitmap and free page counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap          <= '0;
            free_page_count <= '0;
        end else begin
            if (alloc_ok) begin
                bitmap[fl_pop_data] <= 1'b1;
                free_page_count     <= free_page_count - (PAGE_W+1)'(1);
            end
            if (free_ok) bitmap[free_page] <= 1'b0;
            if ((state == ST_INIT) || free_ok) free_page_count <= free_page_count + (PAGE_W+1)'(1);
        end
    end

    // Registered one-cycle responses; all fields return to zero when not writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_rsp_write_en    <= 1'b0;
            alloc_rsp_id          <= '0;
            alloc_rsp_page_idx    <= '0;
            alloc_rsp_fail        <= 1'b0;
            alloc_rsp_fail_reason <= '0;
            free_rsp_write_en     <= 1'b0;
            free_rsp_id           <= '0;
            free_rsp_fail         <= 1'b0;
            free_rsp_fail_reason  <= '0;
        end else begin
            alloc_rsp_write_en    <= 1'b0;
            alloc_rsp_id          <= '0;
            alloc_rsp_page_idx    <= '0;
            alloc_rsp_fail        <= 1'b0;
            alloc_rsp_fail_reason <= REASON_W'(REASON_NONE);
            free_rsp_write_en     <= 1'b0;
            free_rsp_id           <= '0;
            free_rsp_fail         <= 1'b0;
            free_rsp_fail_reason  <= REASON_W'(REASON_NONE);
            if (state == ST_ALLOC) begin
                alloc_rsp_write_en <= 1'b1;
                alloc_rsp_id       <= alloc_id_q;
                if (alloc_size_bad) begin
                    alloc_rsp_fail        <= 1'b1;
                    alloc_rsp_fail_reason <= REASON_W'(REASON_INVALID_SIZE);
                end else if (!alloc_fl_avail_q) begin
                    alloc_rsp_fail        <= 1'b1;
                    alloc_rsp_fail_reason <= REASON_W'(REASON_OUT_OF_MEMORY);
                end else begin
                    alloc_rsp_page_idx <= IDX_W'({fl_pop_data, {SUB_W{1'b0}}});
                end
            end
            if (state == ST_FREE) begin
                free_rsp_write_en <= 1'b1;
                free_rsp_id       <= free_id_q;
                if (free_misaligned) begin
                    free_rsp_fail        <= 1'b1;
                    free_rsp_fail_reason <= REASON_W'(REASON_MISALIGNED);
                end else if (free_out_of_range) begin
                    free_rsp_fail        <= 1'b1;
                    free_rsp_fail_reason <= REASON_W'(REASON_OUT_OF_RANGE);
                end else if (!free_owned) begin
                    free_rsp_fail        <= 1'b1;
                    free_rsp_fail_reason <= REASON_W'(REASON_DOUBLE_FREE);
                end
            end
        end
    end

    // A valid free can never find the free list full: every owned page left it once.
    fl_overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(fl_push && fl_full));

endmodule

// File: tb/tb_mmu_page_pool.sv
// tb/tb_mmu_page_pool.sv - directed self-checking bench for mmu_page_pool
module tb_mmu_page_pool;

    logic        clk;
    logic        rst_n;
    logic        alloc_req_pop;
    logic [7:0]  alloc_req_id;
    logic [2:0]  alloc_req_size;
    logic        alloc_fifo_empty;
    logic        free_req_pop;
    logic [7:0]  free_req_id;
    logic [14:0] free_req_page_idx;
    logic        free_fifo_empty;
    logic        alloc_rsp_write_en;
    logic [7:0]  alloc_rsp_id;
    logic [14:0] alloc_rsp_page_idx;
    logic        alloc_rsp_fail;
    logic [2:0]  alloc_rsp_fail_reason;
    logic        free_rsp_write_en;
    logic [7:0]  free_rsp_id;
    logic        free_rsp_fail;
    logic [2:0]  free_rsp_fail_reason;
    logic        pool_ready;
    logic [3:0]  free_page_count;

    mmu_page_pool #(
        .PAGE_COUNT (8),
        .PAGE_W     (3),
        .SUB_W      (3),
        .IDX_W      (15),
        .ID_W       (8),
        .SIZE_W     (3),
        .REASON_W   (3)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .alloc_req_pop         (alloc_req_pop),
        .alloc_req_id          (alloc_req_id),
        .alloc_req_size        (alloc_req_size),
        .alloc_fifo_empty      (alloc_fifo_empty),
        .free_req_pop          (free_req_pop),
        .free_req_id           (free_req_id),
        .free_req_page_idx     (free_req_page_idx),
        .free_fifo_empty       (free_fifo_empty),
        .alloc_rsp_write_en    (alloc_rsp_write_en),
        .alloc_rsp_id          (alloc_rsp_id),
        .alloc_rsp_page_idx    (alloc_rsp_page_idx),
        .alloc_rsp_fail        (alloc_rsp_fail),
        .alloc_rsp_fail_reason (alloc_rsp_fail_reason),
        .free_rsp_write_en     (free_rsp_write_en),
        .free_rsp_id           (free_rsp_id),
        .free_rsp_fail         (free_rsp_fail),
        .free_rsp_fail_reason  (free_rsp_fail_reason),
        .pool_ready            (pool_ready),
        .free_page_count       (free_page_count)
    );

    typedef struct { logic [7:0] id; logic [2:0] size; } areq_t;
    typedef struct { logic [7:0] id; logic [14:0] idx; } freq_t;
    typedef struct { int cyc; logic [7:0] id; logic [14:0] idx; logic fail; logic [2:0] reason; } arsp_t;
    typedef struct { int cyc; logic [7:0] id; logic fail; logic [2:0] reason; } frsp_t;
    typedef struct { int cyc; bit is_alloc; } pop_t;

    areq_t aq[$];
    freq_t fq[$];
    arsp_t arq[$];
    frsp_t frq[$];
    pop_t  pops[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int init_pops = 0;
    int a_run = 0, a_run_max = 0, f_run = 0, f_run_max = 0;
    int idle_nonzero = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Show-ahead request FIFO models: heads are driven #1 after each edge.
    always begin : pump
        bit pa, pf;
        @(negedge clk);
        pa = alloc_req_pop;
        pf = free_req_pop;
        @(posedge clk);
        #1;
        if (pa && aq.size() > 0) void'(aq.pop_front());
        if (pf && fq.size() > 0) void'(fq.pop_front());
        alloc_fifo_empty = (aq.size() == 0);
        free_fifo_empty  = (fq.size() == 0);
        if (aq.size() > 0) begin alloc_req_id = aq[0].id; alloc_req_size = aq[0].size; end
        else begin alloc_req_id = '0; alloc_req_size = '0; end
        if (fq.size() > 0) begin free_req_id = fq[0].id; free_req_page_idx = fq[0].idx; end
        else begin free_req_id = '0; free_req_page_idx = '0; end
    end

    // Response and pop monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((alloc_req_pop || free_req_pop) && !pool_ready) init_pops++;
            if (alloc_req_pop) pops.push_back('{cyc, 1'b1});
            if (free_req_pop)  pops.push_back('{cyc, 1'b0});
            if (alloc_rsp_write_en) begin
                arq.push_back('{cyc, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason});
                a_run++;
                if (a_run > a_run_max) a_run_max = a_run;
            end else begin
                a_run = 0;
                if (alloc_rsp_id != 0 || alloc_rsp_page_idx != 0 || alloc_rsp_fail || alloc_rsp_fail_reason != 0) idle_nonzero++;
            end
            if (free_rsp_write_en) begin
                frq.push_back('{cyc, free_rsp_id, free_rsp_fail, free_rsp_fail_reason});
                f_run++;
                if (f_run > f_run_max) f_run_max = f_run;
            end else begin
                f_run = 0;
                if (free_rsp_id != 0 || free_rsp_fail || free_rsp_fail_reason != 0) idle_nonzero++;
            end
        end
    end

    task automatic send_alloc(input logic [7:0] id, input logic [2:0] size);
        aq.push_back('{id, size});
    endtask

    task automatic send_free(input logic [7:0] id, input logic [14:0] idx);
        fq.push_back('{id, idx});
    endtask

    task automatic get_arsp(output arsp_t r);
        int n = 0;
        while (arq.size() == 0 && n < 40) begin @(negedge clk); n++; end
        if (arq.size() > 0) r = arq.pop_front();
        else r = '{-1, 'x, 'x, 'x, 'x};
    endtask

    task automatic get_frsp(output frsp_t r);
        int n = 0;
        while (frq.size() == 0 && n < 40) begin @(negedge clk); n++; end
        if (frq.size() > 0) r = frq.pop_front();
        else r = '{-1, 'x, 'x, 'x};
    endtask

    task automatic test_reset;
        int n = 0;
        rst_n = 1'b0;
        alloc_fifo_empty = 1'b1; free_fifo_empty = 1'b1;
        alloc_req_id = '0; alloc_req_size = '0; free_req_id = '0; free_req_page_idx = '0;
        send_alloc(8'h11, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pool_ready !== 1'b0) begin errors++; $display("FAIL reset_pool_ready got=%0b exp=0", pool_ready); end
        checks++; if (free_page_count !== 4'd0) begin errors++; $display("FAIL reset_fpc got=%0d exp=0", free_page_count); end
        checks++; if ({alloc_rsp_write_en, free_rsp_write_en, alloc_req_pop, free_req_pop} !== 4'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0000", {alloc_rsp_write_en, free_rsp_write_en, alloc_req_pop, free_req_pop}); end
        @(negedge clk);
        rst_n = 1'b1;
        while (pool_ready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL init_cycles got=%0d exp=8", n); end
        checks++; if (free_page_count !== 4'd8) begin errors++; $display("FAIL init_fpc got=%0d exp=8", free_page_count); end
        checks++; if (init_pops != 0) begin errors++; $display("FAIL init_pops got=%0d exp=0", init_pops); end
    endtask

    task automatic test_alloc_basic;
        arsp_t r;
        int pc;
        get_arsp(r);
        pc = (pops.size() > 0) ? pops[0].cyc : -100;
        checks++; if (r.id !== 8'h11 || r.idx !== 15'h0000 || r.fail !== 1'b0 || r.reason !== 3'd0) begin
            errors++; $display("FAIL alloc_first got id=%h idx=%h fail=%b rsn=%0d exp id=11 idx=0000 fail=0 rsn=0", r.id, r.idx, r.fail, r.reason); end
        checks++; if (r.cyc - pc != 2) begin errors++; $display("FAIL alloc_latency got=%0d exp=2", r.cyc - pc); end
        send_alloc(8'h12, 3'd0);
        get_arsp(r);
        checks++; if (r.id !== 8'h12 || r.idx !== 15'h0008 || r.fail !== 1'b0) begin
            errors++; $display("FAIL alloc_second got id=%h idx=%h fail=%b exp id=12 idx=0008 fail=0", r.id, r.idx, r.fail); end
        checks++; if (free_page_count !== 4'd6) begin errors++; $display("FAIL alloc_fpc got=%0d exp=6", free_page_count); end
    endtask

    task automatic test_exhaust;
        arsp_t r;
        for (int i = 0; i < 7; i++) send_alloc(8'h20 + 8'(i), 3'(i % 4));
        for (int i = 0; i < 7; i++) begin
            get_arsp(r);
            if (i == 5) begin
                checks++; if (r.idx !== 15'h0038 || r.fail !== 1'b0) begin
                    errors++; $display("FAIL exhaust_last_page got idx=%h fail=%b exp idx=0038 fail=0", r.idx, r.fail); end
            end
            if (i == 6) begin
                checks++; if (r.id !== 8'h26 || r.idx !== 15'h0 || r.fail !== 1'b1 || r.reason !== 3'd2) begin
                    errors++; $display("FAIL exhaust_oom got id=%h idx=%h fail=%b rsn=%0d exp id=26 idx=0 fail=1 rsn=2", r.id, r.idx, r.fail, r.reason); end
            end
        end
        checks++; if (free_page_count !== 4'd0) begin errors++; $display("FAIL exhaust_fpc got=%0d exp=0", free_page_count); end
    endtask

    task automatic test_free_double;
        frsp_t r;
        send_free(8'h30, 15'h0008);
        get_frsp(r);
        checks++; if (r.id !== 8'h30 || r.fail !== 1'b0 || r.reason !== 3'd0) begin
            errors++; $display("FAIL free_ok got id=%h fail=%b rsn=%0d exp id=30 fail=0 rsn=0", r.id, r.fail, r.reason); end
        checks++; if (free_page_count !== 4'd1) begin errors++; $display("FAIL free_ok_fpc got=%0d exp=1", free_page_count); end
        send_free(8'h31, 15'h0008);
        get_frsp(r);
        checks++; if (r.id !== 8'h31 || r.fail !== 1'b1 || r.reason !== 3'd5) begin
            errors++; $display("FAIL double_free got id=%h fail=%b rsn=%0d exp id=31 fail=1 rsn=5", r.id, r.fail, r.reason); end
        checks++; if (free_page_count !== 4'd1) begin errors++; $display("FAIL double_free_fpc got=%0d exp=1", free_page_count); end
    endtask

    task automatic test_bad_size;
        arsp_t r;
        send_alloc(8'h40, 3'd4);
        get_arsp(r);
        checks++; if (r.id !== 8'h40 || r.idx !== 15'h0 || r.fail !== 1'b1 || r.reason !== 3'd1) begin
            errors++; $display("FAIL bad_size got id=%h idx=%h fail=%b rsn=%0d exp id=40 idx=0 fail=1 rsn=1", r.id, r.idx, r.fail, r.reason); end
        checks++; if (free_page_count !== 4'd1) begin errors++; $display("FAIL bad_size_fpc got=%0d exp=1", free_page_count); end
        send_alloc(8'h41, 3'd2);
        get_arsp(r);
        checks++; if (r.idx !== 15'h0008 || r.fail !== 1'b0) begin
            errors++; $display("FAIL bad_size_no_pop got idx=%h fail=%b exp idx=0008 fail=0", r.idx, r.fail); end
        checks++; if (free_page_count !== 4'd0) begin errors++; $display("FAIL bad_size_after_fpc got=%0d exp=0", free_page_count); end
    endtask

    task automatic test_bad_free;
        frsp_t r;
        send_free(8'h50, 15'h0009);
        get_frsp(r);
        checks++; if (r.id !== 8'h50 || r.fail !== 1'b1 || r.reason !== 3'd3) begin
            errors++; $display("FAIL misaligned got id=%h fail=%b rsn=%0d exp id=50 fail=1 rsn=3", r.id, r.fail, r.reason); end
        send_free(8'h51, 15'h0040);
        get_frsp(r);
        checks++; if (r.id !== 8'h51 || r.fail !== 1'b1 || r.reason !== 3'd4) begin
            errors++; $display("FAIL out_of_range got id=%h fail=%b rsn=%0d exp id=51 fail=1 rsn=4", r.id, r.fail, r.reason); end
        checks++; if (free_page_count !== 4'd0) begin errors++; $display("FAIL bad_free_fpc got=%0d exp=0", free_page_count); end
    endtask

    task automatic test_back_to_back;
        arsp_t ar[3];
        frsp_t fr[3];
        int bad_order = 0;
        int bad_gap = 0;
        logic [14:0] exp_idx[3];
        logic        exp_fail[3];
        logic [2:0]  exp_rsn[3];
        exp_idx  = '{15'h0000, 15'h0000, 15'h0010};
        exp_fail = '{1'b1, 1'b0, 1'b0};
        exp_rsn  = '{3'd2, 3'd0, 3'd0};
        pops.delete();
        send_alloc(8'h60, 3'd0); send_alloc(8'h61, 3'd0); send_alloc(8'h62, 3'd0);
        send_free(8'h70, 15'h0000); send_free(8'h71, 15'h0010); send_free(8'h72, 15'h0018);
        for (int i = 0; i < 3; i++) get_arsp(ar[i]);
        for (int i = 0; i < 3; i++) get_frsp(fr[i]);
        for (int i = 0; i < pops.size(); i++) begin
            if (pops[i].is_alloc != (i % 2 == 0)) bad_order++;
            if (i > 0 && pops[i].cyc - pops[i-1].cyc != 2) bad_gap++;
        end
        checks++; if (pops.size() != 6 || bad_order != 0) begin
            errors++; $display("FAIL b2b_pop_order got pops=%0d misordered=%0d exp pops=6 misordered=0", pops.size(), bad_order); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_pop_spacing got bad_gaps=%0d exp=0", bad_gap); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ar[i].id !== 8'h60 + 8'(i) || ar[i].idx !== exp_idx[i] || ar[i].fail !== exp_fail[i] || ar[i].reason !== exp_rsn[i]) begin
                errors++; $display("FAIL b2b_alloc%0d got id=%h idx=%h fail=%b rsn=%0d exp id=%h idx=%h fail=%b rsn=%0d",
                    i, ar[i].id, ar[i].idx, ar[i].fail, ar[i].reason, 8'h60 + 8'(i), exp_idx[i], exp_fail[i], exp_rsn[i]); end
            checks++; if (fr[i].id !== 8'h70 + 8'(i) || fr[i].fail !== 1'b0 || fr[i].reason !== 3'd0) begin
                errors++; $display("FAIL b2b_free%0d got id=%h fail=%b rsn=%0d exp id=%h fail=0 rsn=0", i, fr[i].id, fr[i].fail, fr[i].reason, 8'h70 + 8'(i)); end
        end
        checks++; if (free_page_count !== 4'd1) begin errors++; $display("FAIL b2b_fpc got=%0d exp=1", free_page_count); end
        checks++; if (a_run_max != 1 || f_run_max != 1) begin
            errors++; $display("FAIL wen_one_cycle got alloc_run=%0d free_run=%0d exp 1 and 1", a_run_max, f_run_max); end
        checks++; if (idle_nonzero != 0) begin errors++; $display("FAIL idle_fields_zero got=%0d exp=0", idle_nonzero); end
    endtask

    initial begin
        test_reset();
        test_alloc_basic();
        test_exhaust();
        test_free_double();
        test_bad_size();
        test_bad_free();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmu_page_pool.md
Name: mmu_page_pool

Overview:
- Parametrised 4K-page allocator that replaces the simulation-only page-FIFO model.
- Pops alloc/free requests from the two request FIFOs and serves each from an internal free-list FIFO.
- Keeps a per-page ownership bitmap, so it can reject invalid frees and report allocation failures instead of stalling.
- Sits between the request FIFOs and the response FIFOs of the MMU front end.

Parameters:
- PAGE_COUNT, 4096: number of 4K pages in the pool (power of two, >= 4).
- PAGE_W, 12: width of a 4K page number; equals log2(PAGE_COUNT).
- SUB_W, 3: low index bits selecting the 512B sub-page inside a 4K page.
- IDX_W, 15: full page index width; equals PAGE_W + SUB_W.
- ID_W, 8: request ID width.
- SIZE_W, 3: request size-type width. Size value n means 512B<<n.
- REASON_W, 3: fail reason width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_req_pop  out  1  pop alloc request FIFO
- alloc_req_id  in  ID_W  alloc request ID
- alloc_req_size  in  SIZE_W  alloc size type
- alloc_fifo_empty  in  1  alloc request FIFO empty
- free_req_pop  out  1  pop free request FIFO
- free_req_id  in  ID_W  free request ID
- free_req_page_idx  in  IDX_W  index to free
- free_fifo_empty  in  1  free request FIFO empty
- alloc_rsp_write_en  out  1  alloc response valid, one cycle
- alloc_rsp_id  out  ID_W  echoed ID
- alloc_rsp_page_idx  out  IDX_W  {page, SUB_W'b0}; 0 on fail
- alloc_rsp_fail  out  1  alloc failed
- alloc_rsp_fail_reason  out  REASON_W  reason code
- free_rsp_write_en  out  1  free response valid, one cycle
- free_rsp_id  out  ID_W  echoed ID
- free_rsp_fail  out  1  free failed
- free_rsp_fail_reason  out  REASON_W  reason code
- pool_ready  out  1  initialisation complete
- free_page_count  out  PAGE_W+1  pages currently free

Behaviour:
- Reset:
  - State is INIT; all response outputs are 0.
  - pool_ready=0, free_page_count=0, bitmap all 0 (0 = free), init counter 0.
  - Reset mid-operation discards any in-flight request without a response.
- INIT:
  - Pushes page numbers 0..PAGE_COUNT-1 into the free list, one per cycle.
  - free_page_count increments on each push.
  - After the last push: state goes to IDLE and pool_ready=1, so PAGE_COUNT cycles after reset release.
  - No pops occur during INIT.
- IDLE (arbitration):
  - If both request FIFOs are non-empty, round-robin: serve the type not served last. The last_served flag resets to FREE, so alloc wins the first tie.
  - In the pop cycle T: assert the request pop. For an alloc, also pop the free list only if it is non-empty and the size is valid.
  - Next state is ALLOC or FREE.
- ALLOC (cycle T+1): request fields and free-list data are valid. Checks in priority order:
  1. alloc_req_size > 3 -> fail, reason INVALID_SIZE (1).
  2. Free list empty at T -> fail, reason OUT_OF_MEMORY (2).
  3. Otherwise: set the page's bitmap bit, decrement free_page_count, respond page_idx = {page, 000}.
- FREE (cycle T+1): checks in priority order:
  1. Low SUB_W bits non-zero -> fail, reason MISALIGNED (3).
  2. Page number >= PAGE_COUNT -> fail, reason OUT_OF_RANGE (4); only possible if IDX_W is widened.
  3. Bitmap bit is 0 -> fail, reason DOUBLE_FREE (5).
  4. Otherwise: clear the bit, push the page to the free list, increment free_page_count, respond success.
- Response timing: registered, asserted at T+2 for exactly one cycle. The next IDLE is at T+2, so throughput is one request per 2 cycles.
- Free-list FIFO full with a valid free is unreachable; guard it with an assertion.
- The free list is FIFO-ordered, so pages are reused in least-recently-freed order.
- Reason 0 = NONE whenever fail=0.
- Unused response fields are 0 on any cycle with write_en=0.

Decomposition:
- Shared package holds:
  - fail reason localparams: NONE=0, INVALID_SIZE=1, OUT_OF_MEMORY=2, MISALIGNED=3, OUT_OF_RANGE=4, DOUBLE_FREE=5;
  - REASON_W;
  - MAX_ALLOC_SIZE=3;
  - state encodings: INIT, IDLE, ALLOC, FREE.
- Sub-module: the existing sync_fifo as the free-list store, depth PAGE_COUNT, width PAGE_W.
- The bitmap lives inline as a PAGE_COUNT-bit register.

Test Plan:
- Release reset with PAGE_COUNT=8 -> pool_ready rises after 8 cycles; free_page_count=8; no pops before then.
- Alloc id=0x11 size=3 -> alloc_rsp at T+2: id=0x11, page_idx=0x0000, fail=0; the next alloc returns 0x0008.
- Nine allocs with PAGE_COUNT=8 -> ninth responds fail=1, reason=2, page_idx=0; free_page_count=0.
- Free 0x0008 twice -> first succeeds; second fails with reason=5; free_page_count increments once.
- Free 0x0009 -> fail with reason=3. Alloc size=4 -> fail with reason=1, and the free list is not popped.
- Both FIFOs non-empty continuously -> pops alternate alloc, free, alloc, free; each response has write_en high for one cycle.
